// File: rtl/dallanma_ongorucu_pkg.sv
// Shared constants for the branch predictor: PC width and the 2-bit
// saturating counter encodings used by the prediction table.
package dallanma_ongorucu_pkg;

  localparam int PS_BIT = 32;

  // Strongly not taken / weakly not taken / weakly taken / strongly taken
  localparam logic [1:0] SAYAC_GK = 2'b00;
  localparam logic [1:0] SAYAC_ZK = 2'b01;
  localparam logic [1:0] SAYAC_ZA = 2'b10;
  localparam logic [1:0] SAYAC_GA = 2'b11;

  // Entries come out of reset weakly not taken; fresh allocations start weakly taken
  localparam logic [1:0] SAYAC_RESET = SAYAC_ZK;
  localparam logic [1:0] SAYAC_ALLOC = SAYAC_ZA;

endpackage

// File: rtl/dallanma_ongorucu_doygun_sayac.sv
// Pure combinational 2-bit saturating counter step: increments toward
// strongly taken or decrements toward strongly not taken, clamping at the ends.
module dallanma_ongorucu_doygun_sayac (
  input  logic [1:0] sayac_i,
  input  logic       arttir_i,
  output logic [1:0] sayac_o
);
  import dallanma_ongorucu_pkg::*;

  // Step the counter one position in the requested direction unless already saturated
  always_comb begin
    sayac_o = sayac_i;
    if (arttir_i) begin
      if (sayac_i != SAYAC_GA) begin
        sayac_o = sayac_i + 2'd1;
      end
    end else begin
      if (sayac_i != SAYAC_GK) begin
        sayac_o = sayac_i - 2'd1;
      end
    end
  end

endmodule

// File: rtl/dallanma_ongorucu.sv
// Direct-mapped branch predictor: zero-latency lookup of the fetch PC against a
// table of tagged 2-bit counters with targets, trained by execute-stage feedback,
// plus running counts of feedback updates and mispredicts.
module dallanma_ongorucu #(
  parameter int PS_BIT     = dallanma_ongorucu_pkg::PS_BIT,
  parameter int SATIR      = 64,
  parameter int SATIR_BIT  = $clog2(SATIR),
  parameter int ETIKET_BIT = PS_BIT - 2 - SATIR_BIT,
  parameter int SAYAC_BIT  = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [PS_BIT-1:0]    ps_i,
  input  logic                 ps_gecerli_i,
  output logic                 tahmin_atladi_o,
  output logic [PS_BIT-1:0]    tahmin_ps_o,
  input  logic [PS_BIT-1:0]    g2_ps_i,
  input  logic                 g2_guncelle_i,
  input  logic                 g2_atladi_i,
  input  logic                 g2_hatali_tahmin_i,
  input  logic [PS_BIT-1:0]    g2_hedef_ps_i,
  output logic [SAYAC_BIT-1:0] guncelle_sayisi_o,
  output logic [SAYAC_BIT-1:0] hatali_sayisi_o
);
  import dallanma_ongorucu_pkg::*;

  // Table state
  logic [SATIR-1:0]      gecerli_q, gecerli_d;
  logic [1:0]            sayac_q  [SATIR];
  logic [1:0]            sayac_d  [SATIR];
  logic [ETIKET_BIT-1:0] etiket_q [SATIR];
  logic [ETIKET_BIT-1:0] etiket_d [SATIR];
  logic [PS_BIT-1:0]     hedef_q  [SATIR];
  logic [PS_BIT-1:0]     hedef_d  [SATIR];

  // Statistics
  logic [SAYAC_BIT-1:0]  guncelle_sayisi_q, guncelle_sayisi_d;
  logic [SAYAC_BIT-1:0]  hatali_sayisi_q, hatali_sayisi_d;

  // Lookup side
  logic [SATIR_BIT-1:0]  oku_idx;
  logic [ETIKET_BIT-1:0] oku_etiket;
  logic                  oku_isabet;

  // Update side
  logic [SATIR_BIT-1:0]  g2_idx;
  logic [ETIKET_BIT-1:0] g2_etiket;
  logic                  g2_isabet;
  logic [1:0]            sayac_yeni;

  // The two byte-offset bits never take part in indexing or tagging
  logic                  unused_bayt_bitleri;
  assign unused_bayt_bitleri = ^{ps_i[1:0], g2_ps_i[1:0]};

  assign oku_idx    = ps_i[SATIR_BIT+1:2];
  assign oku_etiket = ps_i[PS_BIT-1:SATIR_BIT+2];
  assign g2_idx     = g2_ps_i[SATIR_BIT+1:2];
  assign g2_etiket  = g2_ps_i[PS_BIT-1:SATIR_BIT+2];

  assign oku_isabet = gecerli_q[oku_idx] && (etiket_q[oku_idx] == oku_etiket);
  assign g2_isabet  = gecerli_q[g2_idx] && (etiket_q[g2_idx] == g2_etiket);

  dallanma_ongorucu_doygun_sayac u_doygun_sayac (
    .sayac_i  (sayac_q[g2_idx]),
    .arttir_i (g2_atladi_i),
    .sayac_o  (sayac_yeni)
  );

  // Prediction reads registered state only, so a same-cycle update is not bypassed
  always_comb begin
    tahmin_atladi_o = ps_gecerli_i && oku_isabet && sayac_q[oku_idx][1];
    tahmin_ps_o     = ps_i + PS_BIT'(4);
    if (tahmin_atladi_o) begin
      tahmin_ps_o = hedef_q[oku_idx];
    end
  end

  // Train the entry addressed by the resolved branch: adjust on hit, allocate on taken miss
  always_comb begin
    gecerli_d = gecerli_q;
    sayac_d   = sayac_q;
    etiket_d  = etiket_q;
    hedef_d   = hedef_q;
    if (g2_guncelle_i) begin
      if (g2_isabet) begin
        sayac_d[g2_idx] = sayac_yeni;
        if (g2_atladi_i) begin
          hedef_d[g2_idx] = g2_hedef_ps_i;
        end
      end else if (g2_atladi_i) begin
        gecerli_d[g2_idx] = 1'b1;
        etiket_d[g2_idx]  = g2_etiket;
        sayac_d[g2_idx]   = SAYAC_ALLOC;
        hedef_d[g2_idx]   = g2_hedef_ps_i;
      end
    end
  end

  // Count every accepted feedback and every accepted mispredict, wrapping naturally
  always_comb begin
    guncelle_sayisi_d = guncelle_sayisi_q;
    hatali_sayisi_d   = hatali_sayisi_q;
    if (g2_guncelle_i) begin
      guncelle_sayisi_d = guncelle_sayisi_q + SAYAC_BIT'(1);
      if (g2_hatali_tahmin_i) begin
        hatali_sayisi_d = hatali_sayisi_q + SAYAC_BIT'(1);
      end
    end
  end

  // Valid bits, counters and statistics clear asynchronously
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      gecerli_q         <= '0;
      for (int i = 0; i < SATIR; i++) begin
        sayac_q[i] <= SAYAC_RESET;
      end
      guncelle_sayisi_q <= '0;
      hatali_sayisi_q   <= '0;
    end else begin
      gecerli_q         <= gecerli_d;
      sayac_q           <= sayac_d;
      guncelle_sayisi_q <= guncelle_sayisi_d;
      hatali_sayisi_q   <= hatali_sayisi_d;
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so they carry no reset
  always_ff @(posedge clk_i) begin
    etiket_q <= etiket_d;
    hedef_q  <= hedef_d;
  end

  assign guncelle_sayisi_o = guncelle_sayisi_q;
  assign hatali_sayisi_o   = hatali_sayisi_q;

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Self-checking bench for dallanma_ongorucu: directed scenarios followed by
// randomized traffic, compared against a simple table model kept here.
module tb_dallanma_ongorucu;

  localparam int SATIR = 64;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] ps_i;
  logic        ps_gecerli_i;
  logic        tahmin_atladi_o;
  logic [31:0] tahmin_ps_o;
  logic [31:0] g2_ps_i;
  logic        g2_guncelle_i;
  logic        g2_atladi_i;
  logic        g2_hatali_tahmin_i;
  logic [31:0] g2_hedef_ps_i;
  logic [31:0] guncelle_sayisi_o;
  logic [31:0] hatali_sayisi_o;

  int checks = 0;
  int errors = 0;

  // Reference model: what each table slot remembers about the last branch trained there
  bit          m_valid [SATIR];
  int unsigned m_tag   [SATIR];
  int          m_conf  [SATIR];
  logic [31:0] m_target[SATIR];
  logic [31:0] m_updates;
  logic [31:0] m_mispredicts;

  dallanma_ongorucu dut (
    .clk_i              (clk_i),
    .rstn_i             (rstn_i),
    .ps_i               (ps_i),
    .ps_gecerli_i       (ps_gecerli_i),
    .tahmin_atladi_o    (tahmin_atladi_o),
    .tahmin_ps_o        (tahmin_ps_o),
    .g2_ps_i            (g2_ps_i),
    .g2_guncelle_i      (g2_guncelle_i),
    .g2_atladi_i        (g2_atladi_i),
    .g2_hatali_tahmin_i (g2_hatali_tahmin_i),
    .g2_hedef_ps_i      (g2_hedef_ps_i),
    .guncelle_sayisi_o  (guncelle_sayisi_o),
    .hatali_sayisi_o    (hatali_sayisi_o)
  );

  // Free-running clock, 10 time units per period
  always #5 clk_i = ~clk_i;

  function automatic int slotOf(input logic [31:0] pc);
    return int'((pc / 4) % SATIR);
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    return int'(pc / (4 * SATIR));
  endfunction

  function automatic bit modelTaken(input logic [31:0] pc, input bit pcValid);
    int s;
    s = slotOf(pc);
    return pcValid && m_valid[s] && (m_tag[s] == tagOf(pc)) && (m_conf[s] >= 2);
  endfunction

  function automatic logic [31:0] modelNext(input logic [31:0] pc, input bit pcValid);
    if (modelTaken(pc, pcValid)) return m_target[slotOf(pc)];
    return pc + 32'd4;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < SATIR; i++) begin
      m_valid[i] = 1'b0;
      m_conf[i]  = 1;
    end
    m_updates     = 32'd0;
    m_mispredicts = 32'd0;
  endtask

  task automatic modelLearn(input logic [31:0] pc, input bit taken, input bit mispred,
                            input logic [31:0] target);
    int s;
    s = slotOf(pc);
    m_updates = m_updates + 32'd1;
    if (mispred) m_mispredicts = m_mispredicts + 32'd1;
    if (m_valid[s] && m_tag[s] == tagOf(pc)) begin
      if (taken) begin
        m_conf[s]   = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
        m_target[s] = target;
      end else begin
        m_conf[s] = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
      end
    end else if (taken) begin
      m_valid[s]  = 1'b1;
      m_tag[s]    = tagOf(pc);
      m_conf[s]   = 2;
      m_target[s] = target;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs while away from the rising edge
  task automatic applyStimulus(input logic [31:0] pc, input bit pcValid, input bit upd,
                               input logic [31:0] gpc, input bit taken, input bit mispred,
                               input logic [31:0] target);
    ps_i               = pc;
    ps_gecerli_i       = pcValid;
    g2_guncelle_i      = upd;
    g2_ps_i            = gpc;
    g2_atladi_i        = taken;
    g2_hatali_tahmin_i = mispred;
    g2_hedef_ps_i      = target;
    #1;
  endtask

  // Compare all outputs against the model's pre-edge view
  task automatic checkOutput(input string tag);
    checkVal({tag, "_taken"},  {31'd0, tahmin_atladi_o}, {31'd0, modelTaken(ps_i, ps_gecerli_i)});
    checkVal({tag, "_nextpc"}, tahmin_ps_o, modelNext(ps_i, ps_gecerli_i));
    checkVal({tag, "_updcnt"}, guncelle_sayisi_o, m_updates);
    checkVal({tag, "_miscnt"}, hatali_sayisi_o, m_mispredicts);
  endtask

  // Advance through the rising edge, let the model learn, and park at the next falling edge
  task automatic tick();
    @(posedge clk_i);
    if (rstn_i && g2_guncelle_i) modelLearn(g2_ps_i, g2_atladi_i, g2_hatali_tahmin_i, g2_hedef_ps_i);
    @(negedge clk_i);
  endtask

  task automatic step(input string tag, input logic [31:0] pc, input bit upd,
                      input logic [31:0] gpc, input bit taken, input bit mispred,
                      input logic [31:0] target);
    applyStimulus(pc, 1'b1, upd, gpc, taken, mispred, target);
    checkOutput(tag);
    tick();
  endtask

  initial begin
    logic [31:0] rpc, rgpc, rtgt;
    modelReset();
    rstn_i = 1'b0;
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk_i);

    // Outputs while reset is held
    checkVal("inreset_taken",  {31'd0, tahmin_atladi_o}, 32'd0);
    checkVal("inreset_nextpc", tahmin_ps_o, 32'h104);
    rstn_i = 1'b1;

    // 1. Cold table
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t1_taken",  {31'd0, tahmin_atladi_o}, 32'd0);
    checkVal("t1_nextpc", tahmin_ps_o, 32'h104);
    checkVal("t1_updcnt", guncelle_sayisi_o, 32'd0);
    checkVal("t1_miscnt", hatali_sayisi_o, 32'd0);
    tick();

    // 2. First taken update allocates
    step("t2a", 32'h500, 1'b1, 32'h100, 1'b1, 1'b1, 32'h180);
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t2_taken",  {31'd0, tahmin_atladi_o}, 32'd1);
    checkVal("t2_nextpc", tahmin_ps_o, 32'h180);
    checkVal("t2_updcnt", guncelle_sayisi_o, 32'd1);
    checkVal("t2_miscnt", hatali_sayisi_o, 32'd1);
    checkOutput("t2");
    tick();

    // 3. Saturate, then walk back down
    repeat (3) step("t3up", 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h180);
    step("t3dn1", 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t3_still_taken", {31'd0, tahmin_atladi_o}, 32'd1);
    tick();
    step("t3dn2", 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t3_now_not_taken", {31'd0, tahmin_atladi_o}, 32'd0);
    checkVal("t3_nextpc", tahmin_ps_o, 32'h104);
    tick();

    // 4. Aliasing in the same slot
    repeat (2) step("t4train", 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h180);
    step("t4alias", 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h300);
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t4_old_evicted", {31'd0, tahmin_atladi_o}, 32'd0);
    checkVal("t4_old_nextpc", tahmin_ps_o, 32'h104);
    tick();
    step("t4missnt", 32'h200, 1'b1, 32'h400, 1'b0, 1'b0, 32'h999);
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t4_new_taken", {31'd0, tahmin_atladi_o}, 32'd1);
    checkVal("t4_new_nextpc", tahmin_ps_o, 32'h300);
    tick();

    // 5. Same-cycle allocate is not bypassed; top-of-memory wrap
    applyStimulus(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h140);
    checkVal("t5_same_cycle", {31'd0, tahmin_atladi_o}, 32'd0);
    tick();
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t5_next_cycle", {31'd0, tahmin_atladi_o}, 32'd1);
    checkVal("t5_next_target", tahmin_ps_o, 32'h140);
    tick();
    applyStimulus(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t5_wrap", tahmin_ps_o, 32'h0);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t5_invalid_fetch", {31'd0, tahmin_atladi_o}, 32'd0);
    tick();
    // Mispredict flag without an update is ignored, as are payloads
    step("t5_noupd", 32'h100, 1'b0, 32'h100, 1'b0, 1'b1, 32'h777);
    checkOutput("t5_after_noupd");

    // Randomized traffic over a few aliasing tags and a handful of slots
    for (int n = 0; n < 300; n++) begin
      rpc  = (32'($urandom_range(0, 3)) * SATIR * 4) + 32'($urandom_range(0, 7)) * 4
             + 32'($urandom_range(0, 3));
      rgpc = (32'($urandom_range(0, 3)) * SATIR * 4) + 32'($urandom_range(0, 7)) * 4;
      rtgt = $urandom & 32'hFFFF_FFFC;
      applyStimulus(rpc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rgpc,
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rtgt);
      checkOutput("rand");
      tick();
    end

    // 6. Asynchronous reset pulse between edges
    step("t6train", 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h180);
    step("t6train", 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h180);
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t6_before", {31'd0, tahmin_atladi_o}, 32'd1);
    rstn_i = 1'b0;
    #1;
    checkVal("t6_reset_taken",  {31'd0, tahmin_atladi_o}, 32'd0);
    checkVal("t6_reset_nextpc", tahmin_ps_o, 32'h104);
    checkVal("t6_reset_updcnt", guncelle_sayisi_o, 32'd0);
    checkVal("t6_reset_miscnt", hatali_sayisi_o, 32'd0);
    rstn_i = 1'b1;
    modelReset();
    tick();
    step("t6after", 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h180);
    checkOutput("t6after_chk");

    // Statistics wrap: preload the update counter at its top value
    applyStimulus(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h180);
    force dut.guncelle_sayisi_q = 32'hFFFF_FFFF;
    #1;
    checkVal("t6_preload", guncelle_sayisi_o, 32'hFFFF_FFFF);
    release dut.guncelle_sayisi_q;
    m_updates = 32'hFFFF_FFFF;
    tick();
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkVal("t6_wrap", guncelle_sayisi_o, 32'd0);
    checkOutput("t6_wrap_chk");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
